// File: rtl/digital_timer_ctrl_if.sv
// Timer/display-side bus of the stopwatch controller: live digits in, timer controls and display digits out.
interface digital_timer_ctrl_if;
    logic [5:0][6:0] clock_digits_in;
    logic            timer_pause;
    logic            timer_clear;
    logic            timer_reset;
    logic [5:0][6:0] display_out;
    logic            lap_active;
    logic [1:0]      state_out;

    modport master (
        input  clock_digits_in,
        output timer_pause, timer_clear, timer_reset, display_out, lap_active, state_out
    );

    modport slave (
        output clock_digits_in,
        input  timer_pause, timer_clear, timer_reset, display_out, lap_active, state_out
    );
endinterface

// File: rtl/digital_timer_ctrl.sv
// Stopwatch controller: debounces start/stop and lap/reset buttons, sequences the timer,
// and freezes the display on a lap snapshot.
module digital_timer_ctrl #(
    parameter int         DEBOUNCE_CYCLES    = 4,
    parameter int         RESET_PULSE_CYCLES = 3,
    parameter logic [6:0] SEG_ZERO           = 7'b0000001
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 btn_start_stop,
    input  logic                 btn_lap_reset,
    digital_timer_ctrl_if.master tif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(RESET_PULSE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        LAP    = 2'd3
    } state_e;

    // Bit 0 carries start/stop, bit 1 carries lap/reset throughout the input path.
    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         deb_q, deb_d;
    logic [1:0]         deb_dly_q, deb_dly_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         press;

    state_e             state_q, state_d;
    logic [PW-1:0]      pulse_q, pulse_d;
    logic [5:0][6:0]    lap_q, lap_d;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
            pulse_q   <= PW'(RESET_PULSE_CYCLES);
            lap_q     <= {6{SEG_ZERO}};
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            lap_q     <= lap_d;
        end
    end

    always_comb begin
        sync1_d   = {btn_lap_reset, btn_start_stop};
        sync2_d   = sync1_q;
        deb_dly_d = deb_q;
        deb_d     = deb_q;
        cnt_d     = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = deb_q & ~deb_dly_q;

    // While a reset pulse runs, presses are swallowed; start/stop beats lap/reset.
    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        lap_d   = lap_q;
        if (pulse_q != '0) begin
            pulse_d = pulse_q - 1'b1;
        end else if (press[0]) begin
            case (state_q)
                IDLE:   state_d = RUN;
                RUN:    state_d = PAUSED;
                LAP:    state_d = PAUSED;
                PAUSED: state_d = RUN;
            endcase
        end else if (press[1]) begin
            case (state_q)
                IDLE:   pulse_d = PW'(RESET_PULSE_CYCLES);
                RUN: begin
                    state_d = LAP;
                    lap_d   = tif.clock_digits_in;
                end
                LAP:    state_d = RUN;
                PAUSED: begin
                    state_d = IDLE;
                    pulse_d = PW'(RESET_PULSE_CYCLES);
                end
            endcase
        end
    end

    assign tif.timer_pause = (state_q == IDLE) || (state_q == PAUSED);
    assign tif.timer_reset = (pulse_q != '0);
    assign tif.timer_clear = (pulse_q != '0);
    assign tif.lap_active  = (state_q == LAP);
    assign tif.display_out = (state_q == LAP) ? lap_q : tif.clock_digits_in;
    assign tif.state_out   = state_q;
endmodule

// File: tb/tb_digital_timer_ctrl.sv
// Bench for digital_timer_ctrl: reference model checked every cycle, state-sequence scoreboard,
// and directed scenarios with literal expectations.
module tb_digital_timer_ctrl;
    localparam int         DEB      = 4;
    localparam int         RPC      = 3;
    localparam logic [6:0] SEG_ZERO = 7'b0000001;

    logic sys_clk;
    logic rst;
    logic btn_start_stop;
    logic btn_lap_reset;

    digital_timer_ctrl_if tif ();

    digital_timer_ctrl #(
        .DEBOUNCE_CYCLES   (DEB),
        .RESET_PULSE_CYCLES(RPC),
        .SEG_ZERO          (SEG_ZERO)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .btn_start_stop(btn_start_stop),
        .btn_lap_reset (btn_lap_reset),
        .tif           (tif)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] exp_q[$];

    // ---------------- clock ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int              m_state;
    int              m_pulse;
    bit [1:0]        m_s1, m_s2, m_deb, m_debp;
    bit              hist[2][$];
    logic [5:0][6:0] m_lap;
    int              nxt_ss[4] = '{1, 2, 1, 2};
    int              nxt_lr[4] = '{0, 3, 0, 1};
    logic [1:0]      prev_state = 2'd0;

    bit              ss_p, lr_p, all_diff;
    bit [1:0]        nd;
    logic [5:0][6:0] exp_disp;

    always @(posedge sys_clk) begin
        if (rst) begin
            m_state = 0;
            m_pulse = RPC;
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_debp = '0;
            hist[0].delete();
            hist[1].delete();
            m_lap = {6{SEG_ZERO}};
        end else begin
            ss_p = m_deb[0] & ~m_debp[0];
            lr_p = m_deb[1] & ~m_debp[1];
            if (m_pulse > 0) begin
                m_pulse--;
            end else if (ss_p) begin
                m_state = nxt_ss[m_state];
            end else if (lr_p) begin
                if (m_state == 0 || m_state == 2) m_pulse = RPC;
                if (m_state == 1) m_lap = tif.clock_digits_in;
                m_state = nxt_lr[m_state];
            end
            // Level flips once the last DEB synchronized samples all disagree with it.
            nd = m_deb;
            for (int i = 0; i < 2; i++) begin
                hist[i].push_back(m_s2[i]);
                if (hist[i].size() > DEB) void'(hist[i].pop_front());
                if (hist[i].size() == DEB) begin
                    all_diff = 1'b1;
                    foreach (hist[i][k]) if (hist[i][k] == m_deb[i]) all_diff = 1'b0;
                    if (all_diff) nd[i] = ~m_deb[i];
                end
            end
            m_debp = m_deb;
            m_deb  = nd;
            m_s2   = m_s1;
            m_s1   = {btn_lap_reset, btn_start_stop};
        end

        #1;
        exp_disp = (m_state == 3) ? m_lap : tif.clock_digits_in;
        check("state_out", tif.state_out, m_state[1:0]);
        check("timer_pause", tif.timer_pause, (m_state == 0 || m_state == 2));
        check("timer_reset", tif.timer_reset, m_pulse > 0);
        check("timer_clear", tif.timer_clear, m_pulse > 0);
        check("lap_active", tif.lap_active, m_state == 3);
        check("display_out", tif.display_out, exp_disp);

        if (tif.state_out !== prev_state) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL state_seq: unexpected change to %0d (no transition left)", tif.state_out);
            end else begin
                check("state_seq", tif.state_out, exp_q.pop_front());
            end
            prev_state = tif.state_out;
        end
    end

    // ---------------- drivers ----------------
    task automatic press(input bit ss, input bit lr, input int hold);
        @(negedge sys_clk);
        if (ss) btn_start_stop = 1'b1;
        if (lr) btn_lap_reset  = 1'b1;
        repeat (hold) @(negedge sys_clk);
        btn_start_stop = 1'b0;
        btn_lap_reset  = 1'b0;
        repeat (30) @(negedge sys_clk);
    endtask

    logic [5:0][6:0] d0, d1, d2, d3;
    int              rst_cnt;

    initial begin
        d0 = {6{SEG_ZERO}};
        d1 = {7'h12, 7'h06, 7'h4C, 7'h24, 7'h4F, 7'h01};
        d2 = {7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h4F};
        d3 = {7'h24, 7'h24, 7'h06, 7'h06, 7'h4C, 7'h12};
        foreach (d0[i]) ;
        exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd1);
        exp_q.push_back(2'd3); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd1); exp_q.push_back(2'd3); exp_q.push_back(2'd0);

        rst = 1'b1;
        btn_start_stop = 1'b0;
        btn_lap_reset  = 1'b0;
        tif.clock_digits_in = d2;

        // Power-on pulse: high before edges 1..3 after release, low afterwards.
        repeat (3) @(negedge sys_clk);
        check("por_state", tif.state_out, 2'd0);
        check("por_pause", tif.timer_pause, 1'b1);
        check("por_display", tif.display_out, d2);
        rst = 1'b0;
        check("por_pulse_0", tif.timer_reset, 1'b1);
        @(negedge sys_clk); check("por_pulse_1", tif.timer_reset, 1'b1);
        @(negedge sys_clk); check("por_pulse_2", tif.timer_clear, 1'b1);
        @(negedge sys_clk); check("por_pulse_3", tif.timer_reset, 1'b0);
        repeat (5) @(negedge sys_clk);

        // Clean press: state still IDLE after edge 5, RUN after edge 6.
        btn_start_stop = 1'b1;
        repeat (6) @(negedge sys_clk);
        check("lat_edge5", tif.state_out, 2'd0);
        @(negedge sys_clk);
        check("lat_edge6", tif.state_out, 2'd1);
        check("run_pause", tif.timer_pause, 1'b0);
        repeat (13) @(negedge sys_clk);
        btn_start_stop = 1'b0;
        repeat (30) @(negedge sys_clk);

        press(1, 0, 20);
        check("paused_state", tif.state_out, 2'd2);
        check("paused_pause", tif.timer_pause, 1'b1);

        // Glitch of 3 cycles is filtered; 4 stable cycles make one transition.
        press(1, 0, 3);
        check("glitch3_state", tif.state_out, 2'd2);
        press(1, 0, 4);
        check("stable4_state", tif.state_out, 2'd1);

        // Lap capture and freeze.
        tif.clock_digits_in = d1;
        press(0, 1, 10);
        check("lap_state", tif.state_out, 2'd3);
        tif.clock_digits_in = d2;
        @(negedge sys_clk);
        check("lap_frozen", tif.display_out, d1);
        check("lap_active", tif.lap_active, 1'b1);
        check("lap_counting", tif.timer_pause, 1'b0);
        press(0, 1, 10);
        check("unlap_state", tif.state_out, 2'd1);
        check("unlap_live", tif.display_out, d2);

        // PAUSED + lap/reset: 3-cycle pulse; start/stop landing inside it is ignored.
        press(1, 0, 10);
        @(negedge sys_clk);
        btn_lap_reset = 1'b1;
        rst_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (i == 0) btn_start_stop = 1'b1;
            if (i == 8) btn_lap_reset = 1'b0;
            if (i == 9) btn_start_stop = 1'b0;
            if (tif.timer_reset) rst_cnt++;
        end
        check("pulse_len", rst_cnt, RPC);
        check("pulse_ignored_ss", tif.state_out, 2'd0);
        press(1, 0, 10);
        check("after_pulse_run", tif.state_out, 2'd1);

        // Simultaneous presses from RUN: start/stop wins, no lap.
        press(1, 1, 10);
        check("both_state", tif.state_out, 2'd2);
        check("both_no_lap", tif.lap_active, 1'b0);

        // Async reset while in LAP.
        press(1, 0, 10);
        tif.clock_digits_in = d3;
        press(0, 1, 10);
        check("lap2_display", tif.display_out, d3);
        tif.clock_digits_in = d1;
        @(negedge sys_clk);
        rst = 1'b1;
        #1;
        check("async_state", tif.state_out, 2'd0);
        check("async_lap", tif.lap_active, 1'b0);
        check("async_pulse", tif.timer_reset, 1'b1);
        check("async_display", tif.display_out, d1);
        @(negedge sys_clk);
        rst = 1'b0;
        repeat (10) @(negedge sys_clk);

        check("seq_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/digital_timer_ctrl.md
Name: digital_timer_ctrl

Overview:
- Button-driven stopwatch controller that sequences the digital timer.
- Debounces two raw push-buttons (start/stop, lap/reset) and runs a 4-state FSM.
- Drives the timer's pause, clear and reset controls.
- Latches a lap snapshot of the 6-digit 7-segment bus and muxes live or lap digits to the display.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable sys_clk cycles needed before a debounced level flips. Legal values are 1 and above.
- RESET_PULSE_CYCLES, 3: length in sys_clk cycles of the timer_reset/timer_clear pulse. Legal values are 1 and above.
- SEG_ZERO, 7'b0000001: segment encoding of digit 0, used for lap register reset.

Ports:
- sys_clk  in  1  system clock, all flops rising-edge.
- rst  in  1  asynchronous, active-high reset.
- btn_start_stop  in  1  raw asynchronous button, active-high.
- btn_lap_reset  in  1  raw asynchronous button, active-high.
- clock_digits_in  in  [5:0][6:0]  live segment digits from the timer. Index 0 is the seconds LSD, index 5 is the hours MSD.
- timer_pause  out  1  holds the timer count.
- timer_clear  out  1  clears the timer tick counter.
- timer_reset  out  1  resets the timer digits to 00:00:00.
- display_out  out  [5:0][6:0]  digits to the display.
- lap_active  out  1  display is frozen on the lap snapshot.
- state_out  out  2  FSM state: IDLE=0, RUN=1, PAUSED=2, LAP=3.

Behaviour:
- Reset (rst=1, async):
  - state=IDLE, lap_active=0, lap_reg = all digits SEG_ZERO.
  - Debounced levels=0, synchronizers=0.
  - Pulse counter loaded with RESET_PULSE_CYCLES, so timer_reset=timer_clear=1 while rst is high and for RESET_PULSE_CYCLES edges after release.
  - timer_pause=1 and display_out=clock_digits_in.
- Input path, per button:
  - 2-flop synchronizer feeds a debounce counter.
  - The counter increments while the sync output differs from the debounced level and zeroes when they are equal.
  - When count==DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter zeroes.
  - press = debounced & ~debounced_d, one cycle wide; release is ignored.
- Latency: take edge 0 as the first edge sampling raw=1 on a clean press. The debounced level rises after edge DEBOUNCE_CYCLES+1, and state_out updates at edge DEBOUNCE_CYCLES+2.
- FSM, where ss = start/stop press and lr = lap/reset press:
  - IDLE: ss goes to RUN. lr starts a reset pulse and stays in IDLE.
  - RUN: ss goes to PAUSED. lr goes to LAP, and lap_reg captures clock_digits_in on the same edge.
  - LAP: the timer keeps counting. ss goes to PAUSED and releases the lap. lr goes to RUN and releases the lap.
  - PAUSED: ss goes to RUN. lr goes to IDLE and starts a reset pulse.
- Simultaneous ss and lr in one cycle: ss wins and lr is dropped.
- Reset pulse in progress (pulse counter non-zero):
  - timer_reset=timer_clear=1.
  - All presses are ignored and the state is held.
  - Debouncers keep running.
- Output decode (combinational from registers):
  - timer_pause=1 in IDLE and PAUSED, 0 in RUN and LAP.
  - lap_active=1 only in LAP.
  - display_out = lap_active ? lap_reg : clock_digits_in.
- Button glitches shorter than DEBOUNCE_CYCLES cycles after sync produce no press.
- Held button: one press only. A new press needs a debounced release first.
- rst asserted mid-operation: immediate async return to the reset values above. Any in-flight lap or pulse is abandoned and a fresh power-on pulse runs.

Test Plan:
- Power-on, DEBOUNCE_CYCLES=4, RESET_PULSE_CYCLES=3: release rst, then timer_reset=timer_clear=1 for 3 edges, then 0. state_out=0, timer_pause=1, display_out equals clock_digits_in.
- Clean ss press held 20 cycles from IDLE: state_out=1 at edge 6, timer_pause=0. A second press 30 cycles later gives state_out=2 and timer_pause=1.
- Glitch: btn_start_stop high for 3 cycles: no state change. High for 4+ stable cycles: exactly one transition.
- Lap: in RUN with clock_digits_in={0x01,0x4F,..}, lr press gives state_out=3, lap_active=1, and display_out frozen while clock_digits_in changes. Next lr press gives state_out=1 and display_out live again.
- PAUSED with lr press: state_out=0, timer_reset/timer_clear high exactly 3 cycles. An ss press during the pulse is ignored; an ss press after it gives RUN.
- Both buttons pressed in the same cycle from RUN: PAUSED, no lap capture. Assert rst while in LAP: async return to IDLE with lap_active=0 and lap_reg=SEG_ZERO.
